// File: rtl/axi_rd_pkg.sv
// rtl/axi_rd_pkg.sv - shared types and constants for the AXI read burst scheduler
package axi_rd_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } rresp_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam int         AXI_4KB    = 4096;

    function automatic logic [12:0] min13(input logic [12:0] a, input logic [12:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/burst_len_fifo.sv
// rtl/burst_len_fifo.sv - small synchronous FIFO of issued burst lengths
module burst_len_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/axi_rd_burst_sched.sv
// rtl/axi_rd_burst_sched.sv - splits a read descriptor into 4 KB-safe AXI4 INCR bursts
module axi_rd_burst_sched
    import axi_rd_pkg::*;
#(
    parameter int C_M_AXI_BURST_LEN  = 256,
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 16,
    parameter int CMD_BEATS_WIDTH    = 16,
    parameter int MAX_OUTSTANDING    = 4
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          CMD_VALID,
    output logic                          CMD_READY,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [CMD_BEATS_WIDTH-1:0]    CMD_BEATS,
    output logic                          BUSY,
    output logic                          DONE,
    output logic                          ERROR,
    output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    output logic [1:0]                    M_AXI_ARBURST,
    output logic                          M_AXI_ARLOCK,
    output logic [3:0]                    M_AXI_ARCACHE,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic [3:0]                    M_AXI_ARQOS,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] DOUT_DATA,
    output logic                          DOUT_VALID,
    input  logic                          DOUT_READY,
    output logic                          DOUT_LAST
);
    localparam int          BYTES     = C_M_AXI_DATA_WIDTH / 8;
    localparam int          SIZE_LOG2 = $clog2(BYTES);
    localparam int          OUT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int          AW        = C_M_AXI_ADDR_WIDTH;
    localparam int          BW        = CMD_BEATS_WIDTH;
    localparam logic [12:0] BURST_MAX = 13'(C_M_AXI_BURST_LEN);

    state_t            state_q;
    logic [AW-1:0]     addr_q;
    logic [BW-1:0]     remaining_q;
    logic [BW-1:0]     rx_left_q;
    logic [OUT_W-1:0]  outstanding_q;
    logic [8:0]        beat_cnt_q;
    logic [8:0]        len_q;
    logic              arvalid_q;
    logic [AW-1:0]     araddr_q;
    logic [7:0]        arlen_q;
    logic              cmd_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    logic [12:0] room_beats;
    logic [12:0] rem_cap;
    logic [12:0] len_calc;
    logic        ar_hs;
    logic        r_hs;
    logic        r_gate;
    logic        burst_end;
    logic        issue_go;
    logic        misaligned;
    logic        cmd_accept;
    logic [8:0]  fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        rid_unused;

    assign rid_unused = ^M_AXI_RID;

    // Beats left before the next 4 KB page, kept in 13 bits so a full page (2048+) fits.
    assign room_beats = (13'(AXI_4KB) - {1'b0, addr_q[11:0]}) / 13'(BYTES);
    assign rem_cap    = (remaining_q > BW'(C_M_AXI_BURST_LEN)) ? BURST_MAX : 13'(remaining_q);
    assign len_calc   = min13(rem_cap, room_beats);

    assign misaligned = (CMD_ADDR & AW'(BYTES - 1)) != '0;
    assign cmd_accept = CMD_VALID && cmd_ready_q;
    assign ar_hs      = arvalid_q && M_AXI_ARREADY;
    assign r_gate     = (outstanding_q != '0);
    assign r_hs       = M_AXI_RVALID && M_AXI_RREADY;
    assign burst_end  = !fifo_empty && (beat_cnt_q == fifo_head - 9'd1);
    assign issue_go   = (state_q == ISSUE) && !arvalid_q && (remaining_q != '0)
                        && (outstanding_q < OUT_W'(MAX_OUTSTANDING)) && !fifo_full;

    assign CMD_READY     = cmd_ready_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign ERROR         = error_q;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = arlen_q;
    assign M_AXI_ARSIZE  = 3'(SIZE_LOG2);
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARVALID = arvalid_q;

    // Beats are only taken while a burst is known to be in flight.
    assign M_AXI_RREADY = DOUT_READY && r_gate;
    assign DOUT_VALID   = M_AXI_RVALID && r_gate;
    assign DOUT_DATA    = M_AXI_RDATA;
    assign DOUT_LAST    = r_gate && (rx_left_q == BW'(1));

    burst_len_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (9)
    ) u_len_fifo (
        .clk_i   (M_AXI_ACLK),
        .rst_ni  (M_AXI_ARESETN),
        .push_i  (ar_hs),
        .data_i  (len_q),
        .pop_i   (r_hs && burst_end),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            rx_left_q     <= '0;
            outstanding_q <= '0;
            beat_cnt_q    <= '0;
            len_q         <= '0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (ar_hs) begin
                arvalid_q   <= 1'b0;
                addr_q      <= addr_q + AW'(len_q) * AW'(BYTES);
                remaining_q <= remaining_q - BW'(len_q);
            end

            // The burst ends on the beat count; RLAST is only checked against it.
            if (r_hs) begin
                rx_left_q  <= rx_left_q - BW'(1);
                beat_cnt_q <= burst_end ? 9'd0 : beat_cnt_q + 9'd1;
                if ((M_AXI_RLAST != burst_end) || (rresp_t'(M_AXI_RRESP) != OKAY)) begin
                    error_q <= 1'b1;
                end
            end

            case ({ar_hs, r_hs && burst_end})
                2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
                2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
                default: outstanding_q <= outstanding_q;
            endcase

            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_accept) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        error_q     <= misaligned;
                        addr_q      <= CMD_ADDR;
                        remaining_q <= CMD_BEATS;
                        rx_left_q   <= CMD_BEATS;
                        beat_cnt_q  <= '0;
                        state_q     <= ((CMD_BEATS == '0) || misaligned) ? FINISH : ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_go) begin
                        araddr_q  <= addr_q;
                        arlen_q   <= 8'(len_calc - 13'd1);
                        len_q     <= 9'(len_calc);
                        arvalid_q <= 1'b1;
                    end else if (!arvalid_q && (remaining_q == '0)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding_q == '0) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
